// File: rtl/memory_pkg.sv
// memory_pkg: shared types and helpers for the memory pipeline stage.
//   word_t      - 32-bit data/address word
//   mem_op_t    - memory operation carried down from decode/execute
//   msize_t     - bus transfer size encoding (byte / half / word)
//   mem_state_t - memory-stage bus handshake states
package memory_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
  } mem_op_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE, WAIT_ADDR, WAIT_DATA, DRAIN
  } mem_state_t;

  function automatic logic is_load(mem_op_t op);
    return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
  endfunction

  function automatic logic is_store(mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic msize_t op_size(mem_op_t op);
    case (op)
      LH, LHU, SH: return MSIZE2;
      LW, SW:      return MSIZE4;
      default:     return MSIZE1;
    endcase
  endfunction

  // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic misaligned(mem_op_t op, logic [1:0] addr_lo);
    case (op)
      LH, LHU, SH: return addr_lo[0];
      LW, SW:      return addr_lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a raw bus word
// and sign- or zero-extends it according to the load opcode.
//   op      - load opcode (non-load ops produce 0)
//   addr_lo - low two address bits of the load
//   rdata   - raw 32-bit word from the data bus
//   result  - extended load value
module load_extend
  import memory_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  addr_lo,
  input  word_t       rdata,
  output word_t       result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = rdata[{addr_lo, 3'b000} +: 8];
    half_s = rdata[{addr_lo[1], 4'b0000} +: 16];
    result = '0;
    case (op)
      LB:      result = 32'(byte_s);
      LBU:     result = {24'b0, byte_s};
      LH:      result = 32'(half_s);
      LHU:     result = {16'b0, half_s};
      LW:      result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline memory stage. Issues data-bus requests for loads
// and stores, raises address-error exceptions, extends load data, and stalls
// the pipeline until the bus handshake completes. Flushed transactions are
// always drained so bus response ordering is preserved.
//   clk, reset           - clock, asynchronous active-high reset
//   in_valid/op/addr/wdata - instruction leaving execute (stable while stall)
//   flush                - kill current stage contents
//   dreq_*               - data bus request channel
//   dresp_*              - data bus accept / response channel
//   result, result_valid - extended load value for writeback
//   exc_adel, exc_ades, badvaddr - address-error exception reporting
//   stall                - hold upstream and this stage
module memory_access
  import memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  mem_op_t     in_op,
  input  word_t       in_addr,
  input  word_t       in_wdata,
  input  logic        flush,
  output logic        dreq_valid,
  output logic        dreq_write,
  output word_t       dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output word_t       dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  word_t       dresp_rdata,
  output word_t       result,
  output logic        result_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output word_t       badvaddr,
  output logic        stall
);

  mem_state_t  state;
  logic        killed_p1;
  logic        req_write_p1;
  word_t       req_addr_p1;
  msize_t      req_size_p1;
  logic [3:0]  req_strobe_p1;
  word_t       req_data_p1;
  mem_op_t     req_op_p1;

  logic        ld, st, misal, new_req, issue, owner, complete;
  logic        new_write;
  word_t       new_addr, new_data;
  msize_t      new_size;
  logic [3:0]  new_strobe;
  mem_op_t     ext_op;
  logic [1:0]  ext_lo;
  word_t       ext_result;

  load_extend u_load_extend (
    .op      (ext_op),
    .addr_lo (ext_lo),
    .rdata   (dresp_rdata),
    .result  (ext_result)
  );

  always_comb begin
    ld      = is_load(in_op);
    st      = is_store(in_op);
    misal   = misaligned(in_op, in_addr[1:0]);
    exc_adel = in_valid & ld & misal;
    exc_ades = in_valid & st & misal;
    badvaddr = (exc_adel | exc_ades) ? in_addr : '0;
    new_req = in_valid & (ld | st) & ~misal;
    issue   = (state == IDLE) & new_req & ~flush;
    // The in-flight instruction still owns the stage only if never flushed.
    owner   = ~flush & (((state == WAIT_ADDR) & ~killed_p1) | (state == WAIT_DATA));

    complete = 1'b0;
    case (state)
      IDLE:      complete = issue & dresp_addr_ok & dresp_data_ok;
      WAIT_ADDR: complete = owner & dresp_addr_ok & dresp_data_ok;
      WAIT_DATA: complete = owner & dresp_data_ok;
      default:   complete = 1'b0;
    endcase

    new_write  = st;
    new_addr   = st ? {in_addr[31:2], 2'b00} : in_addr;
    new_size   = op_size(in_op);
    new_strobe = 4'b0000;
    new_data   = in_wdata;
    case (in_op)
      SB: begin
        new_strobe = 4'b0001 << in_addr[1:0];
        new_data   = {4{in_wdata[7:0]}};
      end
      SH: begin
        new_strobe = 4'b0011 << in_addr[1:0];
        new_data   = {2{in_wdata[15:0]}};
      end
      SW:      new_strobe = 4'hf;
      default: new_strobe = 4'b0000;
    endcase

    // A request is never withdrawn once shown: WAIT_ADDR replays the latch.
    dreq_valid  = 1'b0;
    dreq_write  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = 2'd0;
    dreq_strobe = 4'b0000;
    dreq_data   = '0;
    if (issue) begin
      dreq_valid  = 1'b1;
      dreq_write  = new_write;
      dreq_addr   = new_addr;
      dreq_size   = new_size;
      dreq_strobe = new_strobe;
      dreq_data   = new_data;
    end else if (state == WAIT_ADDR) begin
      dreq_valid  = 1'b1;
      dreq_write  = req_write_p1;
      dreq_addr   = req_addr_p1;
      dreq_size   = req_size_p1;
      dreq_strobe = req_strobe_p1;
      dreq_data   = req_data_p1;
    end

    // While a killed response is outstanding, a new memory op must wait.
    if (issue || owner)
      stall = ~complete;
    else if (state != IDLE)
      stall = new_req & ~flush;
    else
      stall = 1'b0;

    ext_op = (state == IDLE) ? in_op : req_op_p1;
    ext_lo = (state == IDLE) ? in_addr[1:0] : req_addr_p1[1:0];
    result_valid = complete | (in_valid & (in_op == MEM_NONE) & ~flush);
    result       = (complete & is_load(ext_op)) ? ext_result : '0;
  end

  // Request latch / handshake state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      killed_p1     <= 1'b0;
      req_write_p1  <= 1'b0;
      req_addr_p1   <= '0;
      req_size_p1   <= MSIZE1;
      req_strobe_p1 <= 4'b0000;
      req_data_p1   <= '0;
      req_op_p1     <= MEM_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            req_write_p1  <= new_write;
            req_addr_p1   <= new_addr;
            req_size_p1   <= new_size;
            req_strobe_p1 <= new_strobe;
            req_data_p1   <= new_data;
            req_op_p1     <= in_op;
            killed_p1     <= 1'b0;
            if (dresp_addr_ok && dresp_data_ok) state <= IDLE;
            else if (dresp_addr_ok)             state <= WAIT_DATA;
            else                                state <= WAIT_ADDR;
          end
        end
        WAIT_ADDR: begin
          if (dresp_addr_ok) begin
            killed_p1 <= 1'b0;
            if (dresp_data_ok)           state <= IDLE;
            else if (killed_p1 || flush) state <= DRAIN;
            else                         state <= WAIT_DATA;
          end else begin
            killed_p1 <= killed_p1 | flush;
          end
        end
        WAIT_DATA: begin
          if (dresp_data_ok) state <= IDLE;
          else if (flush)    state <= DRAIN;
        end
        DRAIN: begin
          if (dresp_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access. Inputs are driven 1 time unit after
// the rising edge and outputs sampled on the falling edge. Expected results are
// queued when stimulus is driven; a monitor pops one per result_valid cycle.
module tb_memory_access;
  import memory_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  mem_op_t    in_op;
  word_t      in_addr, in_wdata;
  logic       flush;
  logic       dreq_valid, dreq_write;
  word_t      dreq_addr, dreq_data;
  logic [1:0] dreq_size;
  logic [3:0] dreq_strobe;
  logic       dresp_addr_ok, dresp_data_ok;
  word_t      dresp_rdata;
  word_t      result;
  logic       result_valid, exc_adel, exc_ades, stall;
  word_t      badvaddr;

  int    checks   = 0;
  int    failures = 0;
  word_t exp_q[$];

  always #5 clk = ~clk;

  memory_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
    .dresp_rdata(dresp_rdata), .result(result), .result_valid(result_valid),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .badvaddr(badvaddr), .stall(stall)
  );

  // Scoreboard: every result_valid cycle must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && result_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected result_valid got result=%h with no expectation", result);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        if (result !== e) begin
          failures++;
          $display("FAIL sb_result got=%h exp=%h", result, e);
        end
      end
    end
  end

  // Reference load extension written as shift/mask rather than lane select.
  function automatic word_t model_load(mem_op_t op, word_t a, word_t d);
    word_t v;
    case (op)
      LB:  begin v = (d >> (8 * a[1:0])) & 32'hff;   if (v[7])  v = v | 32'hffffff00; end
      LBU: v = (d >> (8 * a[1:0])) & 32'hff;
      LH:  begin v = (d >> (16 * a[1])) & 32'hffff; if (v[15]) v = v | 32'hffff0000; end
      LHU: v = (d >> (16 * a[1])) & 32'hffff;
      LW:  v = d;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_op = MEM_NONE; in_addr = '0; in_wdata = '0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dreq_valid, stall, result_valid, exc_adel, exc_ades} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {dreq_valid, stall, result_valid, exc_adel, exc_ades});
    end
    checks++;
    if (badvaddr !== 32'h0 || result !== 32'h0 || dreq_strobe !== 4'h0) begin
      failures++;
      $display("FAIL reset_data got badvaddr=%h result=%h strobe=%h exp=0", badvaddr, result, dreq_strobe);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_lw_fast();
    in_valid = 1'b1; in_op = LW; in_addr = 32'h1000;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_rdata = 32'hDEADBEEF;
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_write !== 1'b0 || dreq_addr !== 32'h1000 ||
        dreq_size !== 2'd2 || dreq_strobe !== 4'h0) begin
      failures++;
      $display("FAIL lw_fast_req got v=%b w=%b a=%h s=%0d st=%h exp v=1 w=0 a=00001000 s=2 st=0",
               dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_strobe);
    end
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL lw_fast_stall got=%b exp=0", stall); end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_load_extend();
    mem_op_t ops[2] = '{LB, LBU};
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = ops[i]; in_addr = 32'h1003;
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_rdata = 32'h80FF_0000;
      exp_q.push_back(i == 0 ? 32'hFFFFFF80 : 32'h00000080);
      @(negedge clk);
      checks++;
      if (dreq_addr !== 32'h1003 || dreq_size !== 2'd0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL byte_load_req got a=%h s=%0d stall=%b exp a=00001003 s=0 stall=0",
                 dreq_addr, dreq_size, stall);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_store();
    in_valid = 1'b1; in_op = SH; in_addr = 32'h2002; in_wdata = 32'h1234ABCD;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_write !== 1'b1 || dreq_strobe !== 4'b1100 ||
        dreq_data !== 32'hABCDABCD || dreq_size !== 2'd1 || dreq_addr !== 32'h2000) begin
      failures++;
      $display("FAIL sh_req got v=%b w=%b st=%b d=%h s=%0d a=%h exp 1 1 1100 abcdabcd 1 00002000",
               dreq_valid, dreq_write, dreq_strobe, dreq_data, dreq_size, dreq_addr);
    end
    next_cycle();
    in_op = SW; in_addr = 32'h2008; in_wdata = 32'hCAFEF00D;
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks++;
    if (dreq_strobe !== 4'hf || dreq_data !== 32'hCAFEF00D || dreq_size !== 2'd2 || stall !== 1'b0) begin
      failures++;
      $display("FAIL sw_req got st=%h d=%h s=%0d stall=%b exp f cafef00d 2 0",
               dreq_strobe, dreq_data, dreq_size, stall);
    end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_misalign();
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_op = LH; in_addr = 32'h3001;
      @(negedge clk);
      checks++;
      if (exc_adel !== 1'b1 || exc_ades !== 1'b0 || badvaddr !== 32'h3001 ||
          dreq_valid !== 1'b0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL lh_adel got adel=%b ades=%b bva=%h dv=%b stall=%b exp 1 0 00003001 0 0",
                 exc_adel, exc_ades, badvaddr, dreq_valid, stall);
      end
      next_cycle();
    end
    in_op = SW; in_addr = 32'h3002;
    @(negedge clk);
    checks++;
    if (exc_ades !== 1'b1 || exc_adel !== 1'b0 || badvaddr !== 32'h3002 || dreq_valid !== 1'b0) begin
      failures++;
      $display("FAIL sw_ades got ades=%b adel=%b bva=%h dv=%b exp 1 0 00003002 0",
               exc_ades, exc_adel, badvaddr, dreq_valid);
    end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_wait_states();
    int stall_cnt = 0;
    in_valid = 1'b1; in_op = LW; in_addr = 32'h4004; dresp_rdata = 32'hCAFE1234;
    exp_q.push_back(32'hCAFE1234);
    for (int c = 0; c < 6; c++) begin
      dresp_addr_ok = (c == 3);
      dresp_data_ok = (c == 5);
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (c <= 3) begin
        checks++;
        if (dreq_valid !== 1'b1 || dreq_addr !== 32'h4004 || dreq_size !== 2'd2 || dreq_write !== 1'b0) begin
          failures++;
          $display("FAIL wait_req_stable c=%0d got v=%b a=%h s=%0d exp 1 00004004 2", c, dreq_valid, dreq_addr, dreq_size);
        end
      end else if (c == 4) begin
        checks++;
        if (dreq_valid !== 1'b0) begin failures++; $display("FAIL wait_data_noreq got=%b exp=0", dreq_valid); end
      end
      next_cycle();
    end
    checks++;
    if (stall_cnt != 5) begin failures++; $display("FAIL wait_stall_cycles got=%0d exp=5", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_flush_wait_addr();
    in_valid = 1'b1; in_op = SB; in_addr = 32'h7001; in_wdata = 32'h000000A5;
    @(negedge clk);
    checks++;
    if (dreq_strobe !== 4'b0010 || dreq_data !== 32'hA5A5A5A5 || dreq_addr !== 32'h7000 || stall !== 1'b1) begin
      failures++;
      $display("FAIL sb_req got st=%b d=%h a=%h stall=%b exp 0010 a5a5a5a5 00007000 1",
               dreq_strobe, dreq_data, dreq_addr, stall);
    end
    next_cycle(); idle_inputs(); flush = 1'b1;
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_strobe !== 4'b0010 || dreq_addr !== 32'h7000 || stall !== 1'b0) begin
      failures++;
      $display("FAIL flush_req_held got v=%b st=%b a=%h stall=%b exp 1 0010 00007000 0",
               dreq_valid, dreq_strobe, dreq_addr, stall);
    end
    next_cycle(); idle_inputs(); dresp_addr_ok = 1'b1;
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1) begin failures++; $display("FAIL flush_addr_ok_req got=%b exp=1", dreq_valid); end
    next_cycle(); idle_inputs(); dresp_data_ok = 1'b1; dresp_rdata = 32'h5555AAAA;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL flush_drop_rv got=%b exp=0", result_valid); end
    next_cycle(); idle_inputs();
    in_valid = 1'b1; in_op = LW; in_addr = 32'h7100;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_rdata = 32'h0BADF00D;
    exp_q.push_back(32'h0BADF00D);
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL after_flush_issue got v=%b stall=%b exp 1 0", dreq_valid, stall);
    end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_flush_drain();
    in_valid = 1'b1; in_op = LW; in_addr = 32'h5000; dresp_addr_ok = 1'b1;
    @(negedge clk);
    next_cycle(); idle_inputs(); flush = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || result_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_wd got stall=%b rv=%b exp 0 0", stall, result_valid);
    end
    next_cycle(); idle_inputs();
    in_valid = 1'b1; in_op = LW; in_addr = 32'h6000;
    exp_q.push_back(32'h11223344);
    for (int c = 0; c < 3; c++) begin
      dresp_data_ok = (c == 2); dresp_rdata = 32'hBAD0BAD0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || dreq_valid !== 1'b0 || result_valid !== 1'b0) begin
        failures++;
        $display("FAIL drain_hold c=%0d got stall=%b dv=%b rv=%b exp 1 0 0", c, stall, dreq_valid, result_valid);
      end
      next_cycle();
    end
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_rdata = 32'h11223344;
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 32'h6000 || stall !== 1'b0) begin
      failures++;
      $display("FAIL drain_reissue got dv=%b a=%h stall=%b exp 1 00006000 0", dreq_valid, dreq_addr, stall);
    end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_nonmem();
    in_valid = 1'b1; in_op = MEM_NONE; in_addr = 32'h1234;
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || stall !== 1'b0 || dreq_valid !== 1'b0) begin
      failures++;
      $display("FAIL nonmem got rv=%b stall=%b dv=%b exp 1 0 0", result_valid, stall, dreq_valid);
    end
    next_cycle(); idle_inputs();
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin failures++; $display("FAIL bubble_rv got=%b exp=0", result_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    mem_op_t ops[5] = '{LB, LBU, LH, LHU, LW};
    for (int i = 0; i < 12; i++) begin
      mem_op_t op;
      word_t a, d;
      op = ops[$urandom_range(0, 4)];
      a  = $urandom & 32'h0000FFFF;
      if (op == LH || op == LHU) a[0] = 1'b0;
      if (op == LW) a[1:0] = 2'b00;
      d  = $urandom;
      in_valid = 1'b1; in_op = op; in_addr = a;
      dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_rdata = d;
      exp_q.push_back(model_load(op, a, d));
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || dreq_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_flow i=%0d got stall=%b dv=%b exp 0 1", i, stall, dreq_valid);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_op = LW; in_addr = 32'h8000;
    @(negedge clk);
    next_cycle(); idle_inputs(); reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got dv=%b stall=%b exp 0 0", dreq_valid, stall);
    end
    next_cycle(); reset = 1'b0;
    in_valid = 1'b1; in_op = LW; in_addr = 32'h8004;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_rdata = 32'h600DCAFE;
    exp_q.push_back(32'h600DCAFE);
    @(negedge clk);
    checks++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 32'h8004 || stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_issue got dv=%b a=%h stall=%b exp 1 00008004 0", dreq_valid, dreq_addr, stall);
    end
    next_cycle(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_lw_fast();
    test_load_extend();
    test_store();
    test_misalign();
    test_wait_states();
    test_flush_wait_addr();
    test_flush_drain();
    test_nonmem();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Pipeline memory stage, directly downstream of execute. Takes the ALU result (address) and forwarded store data for the instruction leaving execute and runs the data-bus request/response handshake for loads and stores. Raises MIPS address-error exceptions, aligns and extends load data, and holds the pipeline (`stall`) until the bus completes. Flushes never corrupt bus ordering: an outstanding response is always drained.

## Interface
Parameters:
- none. Widths come from the shared package (`word_t` = 32 bits).

Ports:
- `clk`  in  1  pipeline clock
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  instruction present in memory stage; inputs held stable while `stall`=1
- `in_op`  in  `mem_op_t`  MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
- `in_addr`  in  32  effective address (execute `aluout`)
- `in_wdata`  in  32  store data (execute `writedata`)
- `flush`  in  1  kill current stage contents (exception/eret from downstream)
- `dreq_valid`  out  1  data request valid
- `dreq_write`  out  1  1 = store
- `dreq_addr`  out  32  word-aligned request address (`addr & ~3` for stores; full addr for loads)
- `dreq_size`  out  2  0 = byte, 1 = half, 2 = word
- `dreq_strobe`  out  4  byte enables (stores only, 0 for loads)
- `dreq_data`  out  32  store data, lane-replicated
- `dresp_addr_ok`  in  1  request accepted
- `dresp_data_ok`  in  1  response / write-ack
- `dresp_rdata`  in  32  raw load word
- `result`  out  32  extended load value (0 for stores/non-mem)
- `result_valid`  out  1  `result` usable this cycle
- `exc_adel`, `exc_ades`  out  1  load / store address error
- `badvaddr`  out  32  faulting address (= `in_addr`)
- `stall`  out  1  hold upstream and this stage

## Operation
- States: IDLE, WAIT_ADDR, WAIT_DATA, DRAIN.
- Misalignment: LH/LHU/SH with `addr[0]`≠0, LW/SW with `addr[1:0]`≠0 → `exc_adel`/`exc_ades`=1 combinationally, no bus request, `stall`=0.
- IDLE, `in_valid`, memory op, no error, no `flush` → `dreq_valid`=1 driven from inputs; request fields latched into registers that cycle.
  - addr_ok & data_ok → complete, stay IDLE.
  - addr_ok only → WAIT_DATA.
  - otherwise → WAIT_ADDR.
- WAIT_ADDR: `dreq_valid` held from latched fields until addr_ok (never withdrawn, even on `flush`). addr_ok & data_ok → IDLE; addr_ok → WAIT_DATA.
- WAIT_DATA: on data_ok → IDLE.
- `flush` in WAIT_ADDR or WAIT_DATA → the instruction is marked killed. After addr_ok it goes to DRAIN. Its data_ok is consumed silently with `result_valid`=0.
- DRAIN: on data_ok → IDLE. A new memory op arriving meanwhile gets `stall`=1 and no request until IDLE.
- Store lanes:
  - SB: strobe `4'b0001<<addr[1:0]`, data `{4{wdata[7:0]}}`.
  - SH: strobe `4'b0011<<addr[1:0]`, data `{2{wdata[15:0]}}`.
  - SW: strobe `4'hf`.
- Load extract: byte `rdata[8*addr[1:0]+:8]`, half `rdata[16*addr[1]+:16]`. Sign-extended for LB/LH, zero-extended for LBU/LHU.
- Non-memory ops pass through: `stall`=0, `result_valid`=1, `result`=0.

## Timing
- Reset: state IDLE, latched fields 0. All outputs 0 (`dreq_valid`, `stall`, `result_valid`, `exc_*`, `badvaddr`, `result`).
- `stall` = (mem op in flight and not completing this cycle) | (new mem op while DRAIN). Deasserts combinationally in the data_ok cycle.
- `result`/`result_valid` are combinational from `dresp_rdata` in the data_ok cycle. Downstream register captures at that edge.
- Minimum latency: 0 extra cycles (addr_ok & data_ok same cycle). Otherwise 1 cycle per wait state.
- `flush` & data_ok in the same cycle → response dropped, IDLE next.
- Reset mid-transaction → IDLE immediately. Bus side is reset together.

## Structure
- Shared package `memory_pkg`: `mem_op_t`, `msize_t` (MSIZE1/2/4), `mem_state_t`.
- One sub-module, `load_extend` (combinational lane select + extension), reused by writeback if needed.
- FSM and request latch in the top module.

## Test plan
- LW addr 0x1000, addr_ok+data_ok same cycle, rdata 0xDEADBEEF → no stall, result 0xDEADBEEF.
- LB addr 0x1003, rdata 0x80FF_0000 → result 0xFFFFFF80. LBU, same inputs → 0x00000080.
- SH addr 0x2002, wdata 0x1234ABCD → strobe 4'b1100, data 0xABCDABCD, size 1.
- LH addr 0x3001 → exc_adel=1, badvaddr 0x3001, dreq_valid never 1. SW addr 0x3002 → exc_ades.
- addr_ok delayed 3 cycles, data_ok 2 more → stall=1 for 5 cycles, dreq fields stable throughout.
- flush in WAIT_DATA, then new LW arrives → LW stalled until old data_ok (result_valid=0), then issued.
